// File: rtl/fifo_word_packer_pkg.sv
// Shared definitions for the FIFO read-side word packer: data width,
// default packing factor, packer FSM encoding and the parity helper.
package fifo_pkg;

  localparam int FIFO_DW            = 8;
  localparam int DEF_BYTES_PER_WORD = 4;

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    FLUSH = 1'b1
  } packer_state_e;

  // Even parity (XOR reduction) over a word zero-extended to 64 bits
  function automatic logic even_parity(input logic [63:0] data);
    even_parity = ^data;
  endfunction

endpackage

// File: rtl/fifo_word_packer_if.sv
// Bus bundle between the FIFO read port, the flush request and the packed
// word output. The master modport is the packer's view.
// Optional feature macro: FIFO_WORD_PACKER_PARITY_EN adds out_parity.
interface fifo_word_packer_if
  import fifo_pkg::*;
#(
  parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
  parameter int CNT_W          = $clog2(BYTES_PER_WORD + 1)
);

  logic                              read_enb;
  logic [FIFO_DW-1:0]                data_out;
  logic                              empty;
  logic                              flush;
  logic                              out_valid;
  logic                              out_ready;
  logic [FIFO_DW*BYTES_PER_WORD-1:0] out_data;
  logic [CNT_W-1:0]                  out_bytes;
`ifdef FIFO_WORD_PACKER_PARITY_EN
  logic                              out_parity;
`endif

  modport master (
    output read_enb,
    input  data_out,
    input  empty,
    input  flush,
    output out_valid,
    input  out_ready,
    output out_data,
`ifdef FIFO_WORD_PACKER_PARITY_EN
    output out_parity,
`endif
    output out_bytes
  );

  modport slave (
    input  read_enb,
    output data_out,
    output empty,
    output flush,
    input  out_valid,
    output out_ready,
    input  out_data,
`ifdef FIFO_WORD_PACKER_PARITY_EN
    input  out_parity,
`endif
    input  out_bytes
  );

endinterface

// File: rtl/fifo_word_packer.sv
// Pops bytes from the 8-bit FIFO and packs BYTES_PER_WORD of them into one
// word (first byte in the low lane), presented on a valid/ready port. A
// flush emits a partial word with its byte count and zeroed upper lanes.
// Optional feature macro: FIFO_WORD_PACKER_PARITY_EN registers out_parity.
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
  parameter int CNT_W          = $clog2(BYTES_PER_WORD + 1)
) (
  input logic                clock,
  input logic                resetn,
  fifo_word_packer_if.master bus
);

  localparam int WORD_W = FIFO_DW * BYTES_PER_WORD;
  localparam int LANE_W = $clog2(BYTES_PER_WORD);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BYTES_PER_WORD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES_PER_WORD - 1);

  typedef logic [BYTES_PER_WORD-1:0][FIFO_DW-1:0] lanes_t;

  packer_state_e    state_r;
  packer_state_e    state_nxt_s;
  lanes_t           acc_r;
  logic [CNT_W-1:0] cnt_r;
  logic             rd_pend_r;
  logic             out_valid_r;
  logic [WORD_W-1:0] out_data_r;
  logic [CNT_W-1:0] out_bytes_r;

  logic             free_s;
  logic [CNT_W-1:0] fill_sum_s;
  logic             read_enb_s;
  logic [LANE_W-1:0] lane_s;
  lanes_t           acc_ins_s;
  lanes_t           masked_s;
  lanes_t           load_data_s;
  logic [CNT_W-1:0] load_bytes_s;
  logic             completes_s;
  logic             flush_act_s;
  logic             full_load_s;
  logic             acc_load_s;
  logic             load_s;
  logic             flush_done_s;

  // cnt + rd_pend never exceeds N: a held full word never has a pop in flight
  assign free_s       = !out_valid_r || bus.out_ready;
  assign fill_sum_s   = cnt_r + CNT_W'(rd_pend_r);
  assign lane_s       = cnt_r[LANE_W-1:0];
  assign completes_s  = rd_pend_r && (cnt_r == CNT_LAST);
  assign flush_act_s  = (state_r == FLUSH) || bus.flush;
  assign full_load_s  = completes_s && free_s;
  // Accumulator-to-output transfer: a stalled full word, or a flushed partial one
  assign acc_load_s   = !rd_pend_r && (cnt_r != CNT_ZERO) && free_s &&
                        ((cnt_r == CNT_FULL) || flush_act_s);
  assign load_s       = full_load_s || acc_load_s;
  assign flush_done_s = !rd_pend_r && ((cnt_r == CNT_ZERO) || acc_load_s);

  // Pop request: only in FILL, and only while the byte will have a home
  always_comb begin
    read_enb_s = 1'b0;
    if ((state_r == FILL) && !bus.empty) begin
      if (fill_sum_s < CNT_FULL) begin
        read_enb_s = 1'b1;
      end else if ((fill_sum_s == CNT_FULL) && rd_pend_r && free_s) begin
        read_enb_s = 1'b1;
      end else begin
        read_enb_s = 1'b0;
      end
    end else begin
      read_enb_s = 1'b0;
    end
  end

  // Accumulator with the arriving byte merged into lane cnt
  always_comb begin
    acc_ins_s = acc_r;
    if (rd_pend_r && (cnt_r < CNT_FULL)) begin
      acc_ins_s[lane_s] = bus.data_out;
    end else begin
      acc_ins_s = acc_r;
    end
  end

  // Accumulator with lanes at or above cnt forced to zero for partial words
  always_comb begin
    masked_s = acc_r;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (i < int'(cnt_r)) begin
        masked_s[i] = acc_r[i];
      end else begin
        masked_s[i] = {FIFO_DW{1'b0}};
      end
    end
  end

  // Select what the output register loads this cycle
  always_comb begin
    load_data_s  = masked_s;
    load_bytes_s = cnt_r;
    if (full_load_s) begin
      load_data_s  = acc_ins_s;
      load_bytes_s = CNT_FULL;
    end else begin
      load_data_s  = masked_s;
      load_bytes_s = cnt_r;
    end
  end

  // FSM next state: a flush stays pending until the partial word has gone out
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      FILL: begin
        if (bus.flush && !flush_done_s) begin
          state_nxt_s = FLUSH;
        end else begin
          state_nxt_s = FILL;
        end
      end
      FLUSH: begin
        if (flush_done_s) begin
          state_nxt_s = FILL;
        end else begin
          state_nxt_s = FLUSH;
        end
      end
      default: state_nxt_s = FILL;
    endcase
  end

  // FSM state, pop tracking, accumulator and byte count
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_r   <= FILL;
      rd_pend_r <= 1'b0;
      acc_r     <= {WORD_W{1'b0}};
      cnt_r     <= CNT_ZERO;
    end else begin
      state_r   <= state_nxt_s;
      rd_pend_r <= read_enb_s;
      acc_r     <= acc_ins_s;
      if (load_s) begin
        cnt_r <= CNT_ZERO;
      end else if (rd_pend_r) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Output register: load when free, otherwise hold until accepted
  always_ff @(posedge clock) begin
    if (!resetn) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {WORD_W{1'b0}};
      out_bytes_r <= CNT_ZERO;
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= load_data_s;
      out_bytes_r <= load_bytes_s;
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

`ifdef FIFO_WORD_PACKER_PARITY_EN
  logic out_parity_r;

  // Parity travels with out_data, zeroed lanes included
  always_ff @(posedge clock) begin
    if (!resetn) begin
      out_parity_r <= 1'b0;
    end else if (load_s) begin
      out_parity_r <= even_parity(64'(load_data_s));
    end else begin
      out_parity_r <= out_parity_r;
    end
  end

  assign bus.out_parity = out_parity_r;
`endif

  assign bus.read_enb  = read_enb_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_bytes = out_bytes_r;

endmodule

// File: doc/fifo_word_packer.md
# fifo_word_packer

Read-side consumer for the 8-bit FIFO. It pops bytes through the FIFO's read port and packs `BYTES_PER_WORD` consecutive bytes into one wide word, which it presents on a valid/ready output port. A flush request emits any partially packed word along with its byte count. It sits directly downstream of the FIFO and drives the FIFO's `read_enb`.

## Interface
Parameters:
- `BYTES_PER_WORD`, default 4: bytes per output word; legal range 2..8.
- `CNT_W`, default `$clog2(BYTES_PER_WORD+1)`: width of the byte counter and of `out_bytes`.

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
- `clock`, in, 1: the single clock; all state updates on its rising edge.
- `resetn`, in, 1: synchronous, active-low reset.
- `read_enb`, out, 1: pop request to the FIFO.
- `data_out`, in, 8: FIFO read data. Valid in the cycle after an accepted pop.
- `empty`, in, 1: FIFO empty flag.
- `flush`, in, 1: single-cycle pulse requesting emission of a partial word.
- `out_valid`, out, 1: output word valid.
- `out_ready`, in, 1: downstream accepts the word.
- `out_data`, out, 8*BYTES_PER_WORD: packed word. First-popped byte is in bits [7:0].
- `out_bytes`, out, CNT_W: number of valid bytes in `out_data`. Equals BYTES_PER_WORD for a full word, 1..BYTES_PER_WORD-1 for a flushed word.
- `out_parity`, out, 1: present only with `FIFO_WORD_PACKER_PARITY_EN`.

## Operation
- State: accumulator `acc`, byte count `cnt` (0..N), pop-in-flight flag `rd_pend`, output register (`out_valid`/`out_data`/`out_bytes`), and FSM {FILL, FLUSH}.
- Output register is "free this cycle" when `!out_valid || out_ready`.
- `read_enb` is combinational from registered state and `empty`. It is high when all of the following hold:
  - state is FILL,
  - `!empty`,
  - either `cnt + rd_pend < N`, or (`cnt + rd_pend == N` and `rd_pend` and the output register is free this cycle).
- `rd_pend` is `read_enb` delayed by one cycle.
- When `rd_pend` is high, `data_out` is written into byte lane `cnt` of `acc`.
- Word completion: when the byte being captured completes the word:
  - If the output register is free, `acc` plus the new byte loads into the output register directly, with `out_bytes`=N, and `cnt` goes to 0.
  - Otherwise the word stays in `acc` with `cnt`=N. It transfers on the first cycle the output register is free, and `cnt` then goes to 0.
- Output handshake:
  - The word transfers on any cycle with `out_valid && out_ready`.
  - `out_data`, `out_bytes` and `out_parity` are held stable while `out_valid && !out_ready`.
- Flush:
  - In FILL, `flush` latches a request and moves to FLUSH. No new pops are issued in FLUSH.
  - In FLUSH, once `rd_pend`=0:
    - If `cnt`=0, return to FILL with no output.
    - Else, when the output register is free, load `acc` with unused lanes zeroed, set `out_bytes`=`cnt`, set `cnt` to 0, and return to FILL.
  - A `flush` pulse while already in FLUSH is absorbed.
  - A `flush` in the same cycle as a completing byte: the full word goes out first, then the flush sees `cnt`=0 and produces no output.
- Reset mid-operation:
  - All state clears and any in-flight byte is discarded.
  - The FIFO shares `resetn`, so no data is lost relative to it.

## Timing
- Reset values: `read_enb`=0, `out_valid`=0, `out_data`=0, `out_bytes`=0, `out_parity`=0, `cnt`=0, `rd_pend`=0, FSM=FILL.
- `read_enb` depends combinationally on `empty` only. There is no path from `out_ready` to `read_enb` except through the "free this cycle" term.
- Latency: with pops in cycles 0..N-1, `out_valid` is high in cycle N+1.
- Throughput: one word every N cycles while the FIFO is non-empty and `out_ready`=1. There are no bubbles.
- Back-pressure stall: at most N bytes are held in `acc` plus one word in the output register. No pops occur beyond that.
- A flush output appears at the earliest 2 cycles after `flush` if a pop was in flight, or 1 cycle after if not.

## Configuration
- `FIFO_WORD_PACKER_PARITY_EN` defined:
  - Adds port `out_parity`, the even parity (XOR) over all `out_data` bits.
  - It is registered together with `out_data` and includes the zeroed lanes.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package `fifo_pkg` holds:
  - the FSM typedef `packer_state_e` {FILL, FLUSH},
  - the default `BYTES_PER_WORD` localparam,
  - the FIFO data width constant (8).
- Single module with no sub-module. The output register is simple enough to stay inline.

## Test plan
- N=4, FIFO preloaded 0x11,0x22,0x33,0x44, `out_ready`=1 -> `read_enb` high for 4 cycles, then one word `out_data`=0x44332211 with `out_bytes`=4, `out_valid` in cycle 5.
- 8 bytes 0x01..0x08, `out_ready`=1 -> words 0x04030201 and 0x08070605 on consecutive N-cycle slots, `read_enb` never drops while FIFO non-empty.
- 3 bytes 0xA1,0xA2,0xA3 then `flush` -> `out_data`=0x00A3A2A1, `out_bytes`=3. With parity enabled, `out_parity` equals the XOR of all bits.
- `out_ready`=0 with 12 bytes available -> exactly 8 pops, then `read_enb` stays 0 and `out_data` is stable. Releasing `out_ready` drains two words with no loss.
- `flush` with `cnt`=0 -> no `out_valid` and FSM returns to FILL. `flush` coinciding with the 4th byte -> one full word and no partial word.
- `resetn` low for 1 cycle mid-word (`cnt`=2, `rd_pend`=1) -> all outputs 0 next cycle, and the next 4 bytes form a fresh word.
